// File: rtl/ptw_axi_pkg.sv
// Shared types and AXI constants for the ITLB page-table-walk read port.
package ptw_axi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } ptw_state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_8B    = 3'b011;
  // Instruction, secure, privileged.
  localparam logic [2:0] PTW_ARPROT     = 3'b101;

  function automatic logic axi_resp_is_err(input logic [1:0] rresp);
    return !((rresp == AXI_RESP_OKAY) || (rresp == AXI_RESP_EXOKAY));
  endfunction

endpackage

// File: rtl/ptw_rd_watchdog.sv
// DATA-phase watchdog for the PTW read port; the module body exists only
// when PTW_RD_TIMEOUT_EN is defined.
`ifdef PTW_RD_TIMEOUT_EN
module ptw_rd_watchdog #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)      count_d = '0;
    else if (inc_i) count_d = count_q + 1'b1;
  end

  // Fires on the cycle that would make the count reach TIMEOUT_CYCLES.
  assign expired_o = inc_i && (count_q == LAST);

  always_ff @(posedge CLK) begin
    if (!RSTN) count_q <= '0;
    else       count_q <= count_d;
  end

endmodule
`endif

// File: rtl/ptw_axi_read_port.sv
// ITLB walker to AXI4 single-beat PTE read bridge.
// Optional DATA-phase timeout with DRAIN state: PTW_RD_TIMEOUT_EN.
//
// state    | meaning
// IDLE     | waiting for a walker request
// ADDR     | AR channel valid, waiting for ARREADY
// DATA     | RREADY high, waiting for the single R beat
// DRAIN    | timed out; swallow the late R beat without responding
module ptw_axi_read_port
  import ptw_axi_pkg::*;
#(
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int ID_WIDTH       = 4,
  parameter int AXI_ID         = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  CLK,
  input  logic                  RSTN,
  input  logic                  REQ_VALID,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR,
  input  logic                  ABORT,
  output logic                  BUSY,
  output logic                  RESP_VALID,
  output logic [DATA_WIDTH-1:0] RESP_DATA,
  output logic                  RESP_ERR,
  output logic                  M_ARVALID,
  input  logic                  M_ARREADY,
  output logic [ADDR_WIDTH-1:0] M_ARADDR,
  output logic [ID_WIDTH-1:0]   M_ARID,
  output logic [7:0]            M_ARLEN,
  output logic [2:0]            M_ARSIZE,
  output logic [1:0]            M_ARBURST,
  output logic [2:0]            M_ARPROT,
  input  logic                  M_RVALID,
  output logic                  M_RREADY,
  input  logic [DATA_WIDTH-1:0] M_RDATA,
  input  logic [1:0]            M_RRESP,
  input  logic                  M_RLAST,
  input  logic [ID_WIDTH-1:0]   M_RID
);

  ptw_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  arvalid_q, arvalid_d;
  logic                  rready_q, rready_d;
  logic                  squash_q, squash_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
  logic                  wd_expired;
  logic                  unused_in;

`ifdef PTW_RD_TIMEOUT_EN
  ptw_rd_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .clr_i     ((state_q == ST_ADDR) && M_ARREADY),
    .inc_i     ((state_q == ST_DATA) && !M_RVALID),
    .expired_o (wd_expired)
  );
  assign unused_in = ^{M_RID, M_RLAST};
`else
  assign wd_expired = 1'b0;
  assign unused_in  = ^{M_RID, M_RLAST, 32'(TIMEOUT_CYCLES)};
`endif

  always_comb begin
    state_d      = state_q;
    araddr_d     = araddr_q;
    squash_d     = squash_q;
    resp_valid_d = 1'b0;
    resp_err_d   = resp_err_q;
    resp_data_d  = resp_data_q;
    case (state_q)
      ST_IDLE: begin
        squash_d = 1'b0;
        if (REQ_VALID && !ABORT) begin
          if (REQ_ADDR[2:0] == 3'b000) begin
            araddr_d = REQ_ADDR;
            state_d  = ST_ADDR;
          end else begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = '0;
          end
        end
      end
      ST_ADDR: begin
        if (ABORT) squash_d = 1'b1;
        if (M_ARREADY) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (ABORT) squash_d = 1'b1;
        if (M_RVALID) begin
          state_d  = ST_IDLE;
          squash_d = 1'b0;
          if (!(squash_q || ABORT)) begin
            resp_valid_d = 1'b1;
            resp_err_d   = axi_resp_is_err(M_RRESP);
            // Zeroed PTE on error so the walker sees pte_v=0.
            resp_data_d  = axi_resp_is_err(M_RRESP) ? '0 : M_RDATA;
          end
        end else if (wd_expired) begin
          state_d = ST_DRAIN;
          if (!(squash_q || ABORT)) begin
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
            resp_data_d  = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (M_RVALID) begin
          state_d  = ST_IDLE;
          squash_d = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    arvalid_d = (state_d == ST_ADDR);
    rready_d  = (state_d == ST_DATA) || (state_d == ST_DRAIN);
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q      <= ST_IDLE;
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      rready_q     <= 1'b0;
      squash_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      araddr_q     <= araddr_d;
      arvalid_q    <= arvalid_d;
      rready_q     <= rready_d;
      squash_q     <= squash_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign BUSY       = (state_q != ST_IDLE);
  assign RESP_VALID = resp_valid_q;
  assign RESP_DATA  = resp_data_q;
  assign RESP_ERR   = resp_err_q;
  assign M_ARVALID  = arvalid_q;
  assign M_ARADDR   = araddr_q;
  assign M_RREADY   = rready_q;
  assign M_ARID     = ID_WIDTH'(AXI_ID);
  assign M_ARLEN    = 8'd0;
  assign M_ARSIZE   = AXI_SIZE_8B;
  assign M_ARBURST  = AXI_BURST_INCR;
  assign M_ARPROT   = PTW_ARPROT;

endmodule

// File: tb/tb_ptw_axi_read_port.sv
// Self-checking bench for ptw_axi_read_port: vector table plus corner sequences.
module tb_ptw_axi_read_port;

  logic        CLK, RSTN, REQ_VALID, ABORT, BUSY, RESP_VALID, RESP_ERR;
  logic [63:0] REQ_ADDR, RESP_DATA, M_ARADDR, M_RDATA;
  logic        M_ARVALID, M_ARREADY, M_RVALID, M_RREADY, M_RLAST;
  logic [3:0]  M_ARID, M_RID;
  logic [7:0]  M_ARLEN;
  logic [2:0]  M_ARSIZE, M_ARPROT;
  logic [1:0]  M_ARBURST, M_RRESP;

  int checks = 0;
  int failures = 0;
  int ar_hs = 0;
  int resp_cnt = 0;

  ptw_axi_read_port #(
    .ADDR_WIDTH(64), .DATA_WIDTH(64), .ID_WIDTH(4), .AXI_ID(0), .TIMEOUT_CYCLES(16)
  ) dut (
    .CLK(CLK), .RSTN(RSTN), .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR), .ABORT(ABORT),
    .BUSY(BUSY), .RESP_VALID(RESP_VALID), .RESP_DATA(RESP_DATA), .RESP_ERR(RESP_ERR),
    .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY), .M_ARADDR(M_ARADDR), .M_ARID(M_ARID),
    .M_ARLEN(M_ARLEN), .M_ARSIZE(M_ARSIZE), .M_ARBURST(M_ARBURST), .M_ARPROT(M_ARPROT),
    .M_RVALID(M_RVALID), .M_RREADY(M_RREADY), .M_RDATA(M_RDATA), .M_RRESP(M_RRESP),
    .M_RLAST(M_RLAST), .M_RID(M_RID)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    if (M_ARVALID && M_ARREADY) ar_hs <= ar_hs + 1;
    if (RESP_VALID) resp_cnt <= resp_cnt + 1;
  end

  typedef struct {
    logic [63:0] addr;
    int          ar_dly;
    int          r_dly;
    logic [1:0]  rresp;
    logic [63:0] rdata;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic do_txn(input vec_t v, input int idx);
    int ar0, rs0;
    ar0 = ar_hs;
    rs0 = resp_cnt;
    REQ_VALID = 1'b1;
    REQ_ADDR  = v.addr;
    tick();
    REQ_VALID = 1'b0;
    if (v.addr[2:0] != 3'b000) begin
      chk($sformatf("v%0d_mis_resp_valid", idx), 64'(RESP_VALID), 64'd1);
      chk($sformatf("v%0d_mis_err", idx), 64'(RESP_ERR), 64'd1);
      chk($sformatf("v%0d_mis_data", idx), RESP_DATA, 64'd0);
      chk($sformatf("v%0d_mis_arvalid", idx), 64'(M_ARVALID), 64'd0);
      chk($sformatf("v%0d_mis_busy", idx), 64'(BUSY), 64'd0);
      tick();
      chk($sformatf("v%0d_mis_pulse", idx), 64'(RESP_VALID), 64'd0);
      chk($sformatf("v%0d_mis_no_ar", idx), 64'(ar_hs - ar0), 64'd0);
      return;
    end
    chk($sformatf("v%0d_arvalid", idx), 64'(M_ARVALID), 64'd1);
    chk($sformatf("v%0d_araddr", idx), M_ARADDR, v.addr);
    chk($sformatf("v%0d_arlen", idx), 64'(M_ARLEN), 64'd0);
    chk($sformatf("v%0d_arsize", idx), 64'(M_ARSIZE), 64'd3);
    chk($sformatf("v%0d_arburst", idx), 64'(M_ARBURST), 64'd1);
    chk($sformatf("v%0d_arprot", idx), 64'(M_ARPROT), 64'd5);
    chk($sformatf("v%0d_busy", idx), 64'(BUSY), 64'd1);
    for (int i = 0; i < v.ar_dly; i++) begin
      // A new request while busy must be ignored.
      REQ_VALID = 1'b1;
      REQ_ADDR  = v.addr ^ 64'h100;
      tick();
      REQ_VALID = 1'b0;
      chk($sformatf("v%0d_arvalid_hold", idx), 64'(M_ARVALID), 64'd1);
      chk($sformatf("v%0d_araddr_hold", idx), M_ARADDR, v.addr);
    end
    M_ARREADY = 1'b1;
    tick();
    M_ARREADY = 1'b0;
    chk($sformatf("v%0d_rready", idx), 64'(M_RREADY), 64'd1);
    chk($sformatf("v%0d_arvalid_drop", idx), 64'(M_ARVALID), 64'd0);
    for (int i = 0; i < v.r_dly; i++) begin
      tick();
      chk($sformatf("v%0d_rready_hold", idx), 64'(M_RREADY), 64'd1);
      chk($sformatf("v%0d_no_early_resp", idx), 64'(RESP_VALID), 64'd0);
    end
    M_RVALID = 1'b1;
    M_RDATA  = v.rdata;
    M_RRESP  = v.rresp;
    M_RLAST  = 1'b1;
    tick();
    M_RVALID = 1'b0;
    M_RDATA  = 64'd0;
    M_RRESP  = 2'b00;
    M_RLAST  = 1'b0;
    chk($sformatf("v%0d_resp_valid", idx), 64'(RESP_VALID), 64'd1);
    chk($sformatf("v%0d_resp_data", idx), RESP_DATA, v.exp_data);
    chk($sformatf("v%0d_resp_err", idx), 64'(RESP_ERR), 64'(v.exp_err));
    chk($sformatf("v%0d_busy_done", idx), 64'(BUSY), 64'd0);
    tick();
    chk($sformatf("v%0d_resp_pulse", idx), 64'(RESP_VALID), 64'd0);
    chk($sformatf("v%0d_data_held", idx), RESP_DATA, v.exp_data);
    chk($sformatf("v%0d_one_ar", idx), 64'(ar_hs - ar0), 64'd1);
    chk($sformatf("v%0d_one_resp", idx), 64'(resp_cnt - rs0), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    int ar0, rs0, n;
    vecs[0] = '{64'h8000_2010, 0, 0, 2'b00, 64'h2000_04CF, 64'h2000_04CF, 1'b0};
    vecs[1] = '{64'h8000_3000, 5, 7, 2'b00, 64'h1234_5678_9ABC_DEF1, 64'h1234_5678_9ABC_DEF1, 1'b0};
    vecs[2] = '{64'h8000_2018, 0, 1, 2'b10, 64'h0000_FFFF, 64'h0, 1'b1};
    vecs[3] = '{64'h8000_2014, 0, 0, 2'b00, 64'h0, 64'h0, 1'b1};
    vecs[4] = '{64'h8000_2020, 2, 0, 2'b11, 64'hDEAD, 64'h0, 1'b1};
    vecs[5] = '{64'h8000_2028, 1, 2, 2'b01, 64'hABCD, 64'hABCD, 1'b0};
    vecs[6] = '{64'h8000_2011, 0, 0, 2'b00, 64'h0, 64'h0, 1'b1};

    RSTN = 1'b0; REQ_VALID = 1'b0; REQ_ADDR = 64'd0; ABORT = 1'b0;
    M_ARREADY = 1'b0; M_RVALID = 1'b0; M_RDATA = 64'd0; M_RRESP = 2'b00;
    M_RLAST = 1'b0; M_RID = 4'd0;
    repeat (3) tick();
    chk("rst_resp_valid", 64'(RESP_VALID), 64'd0);
    chk("rst_resp_data", RESP_DATA, 64'd0);
    chk("rst_resp_err", 64'(RESP_ERR), 64'd0);
    chk("rst_busy", 64'(BUSY), 64'd0);
    chk("rst_arvalid", 64'(M_ARVALID), 64'd0);
    chk("rst_rready", 64'(M_RREADY), 64'd0);
    chk("rst_araddr", M_ARADDR, 64'd0);
    chk("rst_arid", 64'(M_ARID), 64'd0);
    chk("rst_arsize", 64'(M_ARSIZE), 64'd3);
    RSTN = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) do_txn(vecs[i], i);

    // ABORT while in ADDR: AR and R complete, no response.
    ar0 = ar_hs; rs0 = resp_cnt;
    REQ_VALID = 1'b1; REQ_ADDR = 64'h8000_4000; tick(); REQ_VALID = 1'b0;
    ABORT = 1'b1; tick(); ABORT = 1'b0;
    chk("abort_arvalid_hold1", 64'(M_ARVALID), 64'd1);
    tick();
    chk("abort_arvalid_hold2", 64'(M_ARVALID), 64'd1);
    chk("abort_araddr_hold", M_ARADDR, 64'h8000_4000);
    M_ARREADY = 1'b1; tick(); M_ARREADY = 1'b0;
    chk("abort_rready", 64'(M_RREADY), 64'd1);
    chk("abort_busy_data", 64'(BUSY), 64'd1);
    tick();
    M_RVALID = 1'b1; M_RDATA = 64'h5555; tick(); M_RVALID = 1'b0; M_RDATA = 64'd0;
    chk("abort_busy_fall", 64'(BUSY), 64'd0);
    chk("abort_no_resp_valid", 64'(RESP_VALID), 64'd0);
    tick();
    chk("abort_resp_count", 64'(resp_cnt - rs0), 64'd0);
    chk("abort_ar_count", 64'(ar_hs - ar0), 64'd1);
    chk("abort_data_unchanged", RESP_DATA, 64'h0);

    // ABORT and REQ_VALID together in IDLE: no capture.
    REQ_VALID = 1'b1; ABORT = 1'b1; REQ_ADDR = 64'h8000_5000; tick();
    REQ_VALID = 1'b0; ABORT = 1'b0;
    chk("abort_req_busy", 64'(BUSY), 64'd0);
    chk("abort_req_arvalid", 64'(M_ARVALID), 64'd0);

    // New request accepted in the cycle RESP_VALID is high.
    REQ_VALID = 1'b1; REQ_ADDR = 64'h8000_6000; tick(); REQ_VALID = 1'b0;
    M_ARREADY = 1'b1; tick(); M_ARREADY = 1'b0;
    M_RVALID = 1'b1; M_RDATA = 64'h1111; tick(); M_RVALID = 1'b0;
    chk("b2b_first_resp", 64'(RESP_VALID), 64'd1);
    chk("b2b_first_data", RESP_DATA, 64'h1111);
    REQ_VALID = 1'b1; REQ_ADDR = 64'h8000_6008; tick(); REQ_VALID = 1'b0;
    chk("b2b_second_arvalid", 64'(M_ARVALID), 64'd1);
    chk("b2b_second_araddr", M_ARADDR, 64'h8000_6008);
    M_ARREADY = 1'b1; tick(); M_ARREADY = 1'b0;
    M_RVALID = 1'b1; M_RDATA = 64'h2222; tick(); M_RVALID = 1'b0; M_RDATA = 64'd0;
    chk("b2b_second_resp", 64'(RESP_VALID), 64'd1);
    chk("b2b_second_data", RESP_DATA, 64'h2222);
    tick();

    // Reset in the middle of DATA returns everything to reset values.
    REQ_VALID = 1'b1; REQ_ADDR = 64'h8000_7000; tick(); REQ_VALID = 1'b0;
    M_ARREADY = 1'b1; tick(); M_ARREADY = 1'b0;
    RSTN = 1'b0; tick(); RSTN = 1'b1;
    chk("midrst_busy", 64'(BUSY), 64'd0);
    chk("midrst_rready", 64'(M_RREADY), 64'd0);
    chk("midrst_araddr", M_ARADDR, 64'd0);
    chk("midrst_resp_data", RESP_DATA, 64'd0);
    tick();
    do_txn(vecs[0], 10);

`ifdef PTW_RD_TIMEOUT_EN
    // Timeout after 16 DATA cycles, late beat at DATA cycle 40 is drained.
    rs0 = resp_cnt;
    REQ_VALID = 1'b1; REQ_ADDR = 64'h8000_8000; tick(); REQ_VALID = 1'b0;
    M_ARREADY = 1'b1; tick(); M_ARREADY = 1'b0;
    n = 0;
    while (!RESP_VALID && n < 100) begin
      tick();
      n++;
    end
    chk("to_latency", 64'(n), 64'd16);
    chk("to_err", 64'(RESP_ERR), 64'd1);
    chk("to_data", RESP_DATA, 64'd0);
    chk("to_busy", 64'(BUSY), 64'd1);
    chk("to_rready", 64'(M_RREADY), 64'd1);
    repeat (23) tick();
    chk("to_busy_hold", 64'(BUSY), 64'd1);
    M_RVALID = 1'b1; M_RDATA = 64'h7777; tick(); M_RVALID = 1'b0; M_RDATA = 64'd0;
    chk("to_drain_busy", 64'(BUSY), 64'd0);
    chk("to_drain_no_resp", 64'(RESP_VALID), 64'd0);
    tick();
    chk("to_resp_count", 64'(resp_cnt - rs0), 64'd1);
`else
    n = 0;
    ar0 = 0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ptw_axi_read_port.md
# ptw_axi_read_port

Responder side of the ITLB page-table-walk read interface. Accepts one PTE-fetch request at a time from the ITLB walker (address-valid/address), performs a single-beat 64-bit AXI4 read on the instruction-side master port, and returns the PTE as a one-cycle data-valid pulse. Sits between the ITLB and the AXI interconnect. Converts AXI errors, misaligned requests and walker aborts into clean walker-side behaviour.

## Interface
Parameters:
- ADDR_WIDTH, 64: request and AXI address width
- DATA_WIDTH, 64: PTE and RDATA width; fixed at 64
- ID_WIDTH, 4: AXI ID width
- AXI_ID, 0: constant ARID value
- TIMEOUT_CYCLES, 1024: watchdog limit; used only with PTW_RD_TIMEOUT_EN

Ports:
- CLK  in  1  clock; single clock domain
- RSTN  in  1  reset; synchronous, active-low
- REQ_VALID  in  1  walker address valid; connects to ADDR_TO_AXIM_VALID
- REQ_ADDR  in  ADDR_WIDTH  PTE physical address; connects to ADDR_TO_AXIM
- ABORT  in  1  walker abandons the outstanding request (flush/redirect)
- BUSY  out  1  request outstanding; new requests ignored
- RESP_VALID  out  1  one-cycle pulse; connects to DATA_FROM_AXIM_VALID
- RESP_DATA  out  DATA_WIDTH  PTE; connects to DATA_FROM_AXIM
- RESP_ERR  out  1  access error, qualified by RESP_VALID
- M_ARVALID out 1, M_ARREADY in 1, M_ARADDR out ADDR_WIDTH, M_ARID out ID_WIDTH, M_ARLEN out 8, M_ARSIZE out 3, M_ARBURST out 2, M_ARPROT out 3
- M_RVALID in 1, M_RREADY out 1, M_RDATA in DATA_WIDTH, M_RRESP in 2, M_RLAST in 1, M_RID in ID_WIDTH (RID is not checked)

## Operation
- States: IDLE, ADDR, DATA, DRAIN.
- IDLE: if REQ_VALID & ~ABORT: if REQ_ADDR[2:0]==0, latch address and go to ADDR. Otherwise stay in IDLE and issue the error response next cycle.
- ADDR: ARVALID=1 with latched address. ARLEN=0, ARSIZE=3, ARBURST=INCR, ARPROT=3'b101, ARID=AXI_ID. On ARREADY go to DATA.
- DATA: RREADY=1. On RVALID, return to IDLE. Unless squashed, register the response:
  - RRESP OKAY/EXOKAY: RESP_DATA=RDATA, RESP_ERR=0.
  - RRESP SLVERR/DECERR: RESP_DATA=0, RESP_ERR=1. Zero data gives pte_v=0, so the walker raises a page fault.
- ABORT in ADDR or DATA sets a squash flag. ARVALID is held until ARREADY (AXI rule). The R beat is still accepted. No RESP_VALID is produced. The flag clears on return to IDLE.
- DRAIN: entered only on timeout. RREADY=1. The late R beat is discarded; then go to IDLE.
- BUSY = (state != IDLE).
- REQ_VALID while BUSY is ignored, with no queueing.
- ABORT in IDLE has no effect.
- ABORT and REQ_VALID in the same IDLE cycle: ABORT wins and no capture occurs.
- REQ_VALID in the cycle RESP_VALID is high: accepted, because the state is IDLE.
- Reset mid-transaction: all state returns to IDLE. The AXI slave shares RSTN, so the outstanding beat is never delivered.

## Timing
- Reset values: RESP_VALID=0, RESP_DATA=0, RESP_ERR=0, BUSY=0, M_ARVALID=0, M_RREADY=0, M_ARADDR=0. Constant AXI fields are driven at all times.
- Request sampled in cycle N; M_ARVALID rises in N+1.
- ARREADY in N+1 gives RREADY in N+2.
- RVALID in N+2 gives RESP_VALID in N+3. This 3-cycle minimum round trip is the minimum latency.
- Misaligned request in N: RESP_VALID=1, RESP_ERR=1, RESP_DATA=0 in N+1.
- RESP_VALID is always exactly one cycle long. RESP_DATA holds its value until the next response.

## Configuration
- PTW_RD_TIMEOUT_EN defined:
  - A counter clears on entry to DATA and increments each DATA cycle without RVALID.
  - At TIMEOUT_CYCLES it issues RESP_VALID=1, RESP_ERR=1, RESP_DATA=0 (unless squashed) and goes to DRAIN.
  - BUSY stays high until the beat drains.
- Not defined: DATA waits indefinitely. The DRAIN state and the counter are absent.

## Structure
- Shared package ptw_axi_pkg holds:
  - the state enum
  - AXI_RESP_OKAY/EXOKAY/SLVERR/DECERR
  - AXI_BURST_INCR, AXI_SIZE_8B, PTW_ARPROT
- One sub-module, ptw_rd_watchdog (counter plus expiry flag), is instantiated only under PTW_RD_TIMEOUT_EN.

## Test plan
- REQ_ADDR=0x8000_2010, ARREADY and RVALID immediate, RDATA=0x2000_04CF -> ARADDR=0x8000_2010, ARLEN=0, ARSIZE=3; RESP_VALID at N+3 with RESP_DATA=0x2000_04CF, RESP_ERR=0.
- ARREADY delayed 5 cycles and RVALID delayed 7 -> ARVALID and ARADDR stable throughout; one RESP_VALID; second REQ_VALID while BUSY is ignored, with no extra AR.
- RRESP=SLVERR with RDATA=0xFFFF -> RESP_ERR=1, RESP_DATA=0.
- REQ_ADDR=0x8000_2014 -> no ARVALID; RESP_VALID=1, RESP_ERR=1 at N+1.
- ABORT in ADDR with ARREADY 3 cycles later -> AR completes and the R beat is accepted; RESP_VALID is never asserted; BUSY falls after the R beat.
- With PTW_RD_TIMEOUT_EN, TIMEOUT_CYCLES=16, RVALID at 40 -> error RESP_VALID after 16 DATA cycles; BUSY held until cycle 40 drain; no second response.
